// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and constants for the LC-3 memory controller
// Contents:
//   state_t          FSM state encoding (IDLE, WAIT, DONE)
//   DEF_DEPTH_LOG2   default backing-store depth exponent (2^10 words)
//   DEF_WAIT_CYCLES  default extra wait cycles per access
//   CNT_W            wait-counter width (holds 0..15)
package lc3_mem_pkg;

  localparam int DEF_DEPTH_LOG2  = 10;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lc3_mem_array.sv
// rtl/lc3_mem_array.sv - single-port synchronous 16-bit RAM with registered read data
// Ports:
//   i_clock  rising-edge clock
//   i_we     write enable
//   i_addr   word address, DEPTH_LOG2 bits
//   i_wdata  write data
//   o_rdata  read data, registered (word at i_addr as of the previous edge)
// Contents have no reset.
module lc3_mem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  i_clock,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [15:0]           i_wdata,
  output logic [15:0]           o_rdata
);

  logic [15:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [15:0] r_rdata;

  // Read-before-write: a read and write to the same address on one edge
  // returns the old word.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - wait-state memory controller for an LC-3 style processor
// Parameters:
//   DEPTH_LOG2   backing store holds 2^DEPTH_LOG2 16-bit words (must be < 16)
//   WAIT_CYCLES  extra wait cycles per access, 0..15
// Ports:
//   clock     rising-edge system clock
//   reset     asynchronous active-low reset
//   req       access request, sampled only in IDLE
//   addr      word address
//   din       write data
//   rd        1 = read, 0 = write
//   dout      read data, holds the last completed read
//   complete  one-cycle access-done strobe
//   busy      high whenever the FSM is not IDLE
//   err       out-of-range strobe, coincident with complete
// Optional feature: define LC3_MEM_BOUNDS_CHECK_EN to flag accesses with
// nonzero addr[15:DEPTH_LOG2]; otherwise upper bits wrap and err stays 0.
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  input  logic        rd,
  output logic [15:0] dout,
  output logic        complete,
  output logic        busy,
  output logic        err
);

`ifdef LC3_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_addr;
  logic [15:0]        r_din;
  logic               r_rd;
  logic [15:0]        r_dout;
  logic               r_complete;
  logic               r_err;

  logic               w_oob;
  logic               w_we;
  logic [15:0]        w_rdata;

  // With the check disabled this folds to 0, so upper address bits are ignored.
  assign w_oob = BOUNDS_EN && (r_addr[15:DEPTH_LOG2] != '0);

  // The array access happens on the last WAIT edge; the registered read data
  // is then consumed on the DONE edge. Because the write is decoded from the
  // current state, a reset that drops the FSM to IDLE also kills the write.
  assign w_we = (r_state == ST_WAIT) && (r_cnt == '0) && !r_rd && !w_oob;

  lc3_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .i_clock (clock),
    .i_we    (w_we),
    .i_addr  (r_addr[DEPTH_LOG2-1:0]),
    .i_wdata (r_din),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_rd       <= 1'b0;
      r_dout     <= 16'h0000;
      r_complete <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_complete <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_addr  <= addr;
            r_din   <= din;
            r_rd    <= rd;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Strobes are registered here, so they appear in the cycle after DONE.
          r_complete <= 1'b1;
          r_err      <= w_oob;
          if (r_rd) begin
            r_dout <= w_oob ? 16'h0000 : w_rdata;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout     = r_dout;
  assign complete = r_complete;
  assign busy     = (r_state != ST_IDLE);
  assign err      = r_err;

endmodule
